// File: rtl/mem_access_stage_if.sv
// SRAM-like data bus between the MEM stage (master) and the data memory (slave).
interface mem_access_stage_if;
  logic        data_req_o;
  logic        data_wr_o;
  logic [1:0]  data_size_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_addr_ok_i;
  logic        data_data_ok_i;
  logic [31:0] data_rdata_i;

  modport master (
    output data_req_o, data_wr_o, data_size_o, data_addr_o, data_wdata_o,
    input  data_addr_ok_i, data_data_ok_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_wr_o, data_size_o, data_addr_o, data_wdata_o,
    output data_addr_ok_i, data_data_ok_i, data_rdata_i
  );
endinterface

// File: rtl/mem_access_stage.sv
// EX/MEM register plus load/store engine: 1 cycle for non-memory ops, >=3 for bus accesses.
// Stalls upstream from request until data_ok; flushed accesses drain in DISCARD.
module mem_access_stage (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                ex_aluout_i,
  input  logic [31:0]                ex_rdata2_i,
  input  logic [4:0]                 ex_waddr_i,
  input  logic                       ex_we_i,
  input  logic [3:0]                 ex_mem_op_i,
  input  logic [31:0]                ex_pc_i,
  input  logic                       flush_i,
  mem_access_stage_if.master         bus,
  output logic                       stall_o,
  output logic [31:0]                mem_wdata_o,
  output logic [4:0]                 mem_waddr_o,
  output logic                       mem_we_o,
  output logic [31:0]                mem_pc_o,
  output logic                       adel_o,
  output logic                       ades_o,
  output logic [31:0]                badvaddr_o
);
  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                         OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DISCARD} state_t;

  state_t      state_q;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, pc_q, pc_d;
  logic [4:0]  waddr_q, waddr_d;
  logic        we_q, we_d;
  logic [3:0]  op_q, op_d;
  logic        enter, addr_err;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
    case (op)
      OP_LH, OP_LHU, OP_SH: return a[0];
      OP_LW, OP_SW:         return |a;
      default:              return 1'b0;
    endcase
  endfunction

  assign stall_o = (state_q == S_REQ) ||
                   (((state_q == S_WAIT) || (state_q == S_DISCARD)) && !bus.data_data_ok_i);

  // A new access starts only when the register actually loads a live, aligned memory op.
  assign enter = (is_load(ex_mem_op_i) || is_store(ex_mem_op_i)) &&
                 !misaligned(ex_mem_op_i, ex_aluout_i[1:0]) && !flush_i && !stall_o;

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    we_d    = we_q;
    op_d    = op_q;
    pc_d    = pc_q;
    if (flush_i) begin
      addr_d  = '0;
      wdata_d = '0;
      waddr_d = '0;
      we_d    = 1'b0;
      op_d    = '0;
      pc_d    = '0;
    end else if (!stall_o) begin
      addr_d  = ex_aluout_i;
      wdata_d = ex_rdata2_i;
      waddr_d = ex_waddr_i;
      we_d    = ex_we_i;
      op_d    = ex_mem_op_i;
      pc_d    = ex_pc_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      we_q    <= 1'b0;
      op_q    <= '0;
      pc_q    <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      we_q    <= we_d;
      op_q    <= op_d;
      pc_q    <= pc_d;
      case (state_q)
        S_REQ: begin
          if (flush_i)                  state_q <= bus.data_addr_ok_i ? S_DISCARD : S_IDLE;
          else if (bus.data_addr_ok_i)  state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.data_data_ok_i)       state_q <= enter ? S_REQ : S_IDLE;
          else if (flush_i)             state_q <= S_DISCARD;
        end
        S_DISCARD: begin
          if (bus.data_data_ok_i)       state_q <= enter ? S_REQ : S_IDLE;
        end
        default:                        state_q <= enter ? S_REQ : S_IDLE;
      endcase
    end
  end

  assign addr_err   = misaligned(op_q, addr_q[1:0]);
  assign adel_o     = is_load(op_q) && addr_err;
  assign ades_o     = is_store(op_q) && addr_err;
  assign badvaddr_o = addr_q;
  assign mem_we_o   = we_q && !addr_err;
  assign mem_waddr_o = waddr_q;
  assign mem_pc_o   = pc_q;

  assign bus.data_req_o  = (state_q == S_REQ);
  assign bus.data_wr_o   = is_store(op_q);
  assign bus.data_addr_o = addr_q;

  always_comb begin
    bus.data_size_o  = 2'd0;
    bus.data_wdata_o = wdata_q;
    case (op_q)
      OP_LH, OP_LHU: bus.data_size_o = 2'd1;
      OP_LW:         bus.data_size_o = 2'd2;
      OP_SB:         bus.data_wdata_o = {4{wdata_q[7:0]}};
      OP_SH: begin
        bus.data_size_o  = 2'd1;
        bus.data_wdata_o = {2{wdata_q[15:0]}};
      end
      OP_SW:         bus.data_size_o = 2'd2;
      default:       bus.data_size_o = 2'd0;
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_sel = bus.data_rdata_i[7:0];
      2'd1:    byte_sel = bus.data_rdata_i[15:8];
      2'd2:    byte_sel = bus.data_rdata_i[23:16];
      default: byte_sel = bus.data_rdata_i[31:24];
    endcase
    half_sel = addr_q[1] ? bus.data_rdata_i[31:16] : bus.data_rdata_i[15:0];
    case (op_q)
      OP_LB:   mem_wdata_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  mem_wdata_o = {24'd0, byte_sel};
      OP_LH:   mem_wdata_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  mem_wdata_o = {16'd0, half_sel};
      OP_LW:   mem_wdata_o = bus.data_rdata_i;
      default: mem_wdata_o = addr_q;
    endcase
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed and random load/store traffic against an arithmetic reference model of the MEM stage.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ex_aluout, ex_rdata2, ex_pc;
  logic [4:0]  ex_waddr;
  logic        ex_we, flush;
  logic [3:0]  ex_mem_op;
  logic        stall, mem_we, adel, ades;
  logic [31:0] mem_wdata, mem_pc, badvaddr;
  logic [4:0]  mem_waddr;
  int          total = 0;
  int          bad = 0;

  mem_access_stage_if bus_if();

  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .ex_aluout_i(ex_aluout), .ex_rdata2_i(ex_rdata2), .ex_waddr_i(ex_waddr),
    .ex_we_i(ex_we), .ex_mem_op_i(ex_mem_op), .ex_pc_i(ex_pc), .flush_i(flush),
    .bus(bus_if),
    .stall_o(stall), .mem_wdata_o(mem_wdata), .mem_waddr_o(mem_waddr), .mem_we_o(mem_we),
    .mem_pc_o(mem_pc), .adel_o(adel), .ades_o(ades), .badvaddr_o(badvaddr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access width in bytes, alignment, store replication, load extraction.
  function automatic int unsigned acc_bytes(input logic [3:0] op);
    case (op)
      4'd3, 4'd4, 4'd7: return 2;
      4'd5, 4'd8:       return 4;
      4'd1, 4'd2, 4'd6: return 1;
      default:          return 0;
    endcase
  endfunction

  function automatic bit is_mem(input logic [3:0] op);
    return acc_bytes(op) != 0;
  endfunction

  function automatic bit is_st(input logic [3:0] op);
    return op >= 4'd6 && op <= 4'd8;
  endfunction

  function automatic bit mis(input logic [3:0] op, input logic [31:0] addr);
    return is_mem(op) && ((addr % acc_bytes(op)) != 0);
  endfunction

  function automatic logic [31:0] st_val(input logic [3:0] op, input logic [31:0] rt);
    if (op == 4'd6) return (rt & 32'hFF) * 32'h0101_0101;
    if (op == 4'd7) return (rt & 32'hFFFF) * 32'h0001_0001;
    return rt;
  endfunction

  function automatic logic [31:0] ld_val(input logic [3:0] op, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    logic [31:0] v, b, h;
    v = rdata >> (8 * (addr % 4));
    b = v & 32'hFF;
    h = v & 32'hFFFF;
    case (op)
      4'd1:    return (b >= 128) ? b - 32'd256 : b;
      4'd2:    return b;
      4'd3:    return (h >= 32768) ? h - 32'd65536 : h;
      4'd4:    return h;
      default: return rdata;
    endcase
  endfunction

  task automatic drive_ex(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                          input logic [4:0] wa, input logic we, input logic [31:0] pc);
    ex_mem_op = op; ex_aluout = addr; ex_rdata2 = rt; ex_waddr = wa; ex_we = we; ex_pc = pc;
  endtask

  // One instruction through MEM; bus latency set by adly (extra REQ cycles) and ddly (extra WAIT cycles).
  task automatic do_instr(input string nm, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] rt, input logic [31:0] rdata, input logic we,
                          input int adly, input int ddly);
    logic [31:0] pc;
    logic [4:0]  wa;
    pc = $urandom;
    wa = 5'($urandom);
    drive_ex(op, addr, rt, wa, we, pc);
    @(posedge clk); #1;
    if (!is_mem(op) || mis(op, addr)) begin
      drive_ex(4'd0, $urandom, $urandom, 5'd0, 1'b0, 32'd0);
      #1;
      chk({nm, ".req"}, bus_if.data_req_o, 0);
      chk({nm, ".stall"}, stall, 0);
      chk({nm, ".adel"}, adel, mis(op, addr) && !is_st(op));
      chk({nm, ".ades"}, ades, mis(op, addr) && is_st(op));
      chk({nm, ".we"}, mem_we, we && !mis(op, addr));
      chk({nm, ".pc"}, mem_pc, pc);
      chk({nm, ".waddr"}, mem_waddr, wa);
      if (mis(op, addr)) chk({nm, ".badvaddr"}, badvaddr, addr);
      if (!is_mem(op) || is_st(op)) chk({nm, ".wdata"}, mem_wdata, addr);
      return;
    end
    drive_ex(4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom);
    #1;
    chk({nm, ".req"}, bus_if.data_req_o, 1);
    chk({nm, ".wr"}, bus_if.data_wr_o, is_st(op));
    chk({nm, ".size"}, bus_if.data_size_o, acc_bytes(op) >> 1);
    chk({nm, ".addr"}, bus_if.data_addr_o, addr);
    if (is_st(op)) chk({nm, ".stdata"}, bus_if.data_wdata_o, st_val(op, rt));
    chk({nm, ".stall_req"}, stall, 1);
    repeat (adly) begin
      @(posedge clk); #2;
      chk({nm, ".req_hold"}, bus_if.data_req_o, 1);
      chk({nm, ".addr_hold"}, bus_if.data_addr_o, addr);
      chk({nm, ".pc_hold"}, mem_pc, pc);
    end
    bus_if.data_addr_ok_i = 1'b1;
    @(posedge clk); #1;
    bus_if.data_addr_ok_i = 1'b0;
    repeat (ddly + 1) begin
      #1;
      chk({nm, ".req_wait"}, bus_if.data_req_o, 0);
      chk({nm, ".stall_wait"}, stall, 1);
      @(posedge clk); #1;
    end
    bus_if.data_data_ok_i = 1'b1;
    bus_if.data_rdata_i = rdata;
    drive_ex(4'd0, $urandom, $urandom, 5'd0, 1'b0, 32'd0);
    #1;
    chk({nm, ".stall_done"}, stall, 0);
    chk({nm, ".we_done"}, mem_we, we);
    chk({nm, ".pc_done"}, mem_pc, pc);
    if (!is_st(op)) chk({nm, ".ldata"}, mem_wdata, ld_val(op, addr, rdata));
    @(posedge clk); #1;
    bus_if.data_data_ok_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    drive_ex(4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    bus_if.data_addr_ok_i = 1'b0;
    bus_if.data_data_ok_i = 1'b0;
    bus_if.data_rdata_i = 32'h5A5A_5A5A;
    repeat (2) @(posedge clk);
    #2;
    chk("rst.req", bus_if.data_req_o, 0);
    chk("rst.stall", stall, 0);
    chk("rst.we", mem_we, 0);
    chk("rst.wdata", mem_wdata, 0);
    chk("rst.pc", mem_pc, 0);
    chk("rst.adel", adel, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    do_instr("lw", 4'd5, 32'h1000_0004, 32'd0, 32'hDEAD_BEEF, 1'b1, 0, 0);
    do_instr("lb3", 4'd1, 32'h0000_0103, 32'd0, 32'h80FF_7F01, 1'b1, 0, 0);
    do_instr("lbu3", 4'd2, 32'h0000_0103, 32'd0, 32'h80FF_7F01, 1'b1, 1, 0);
    do_instr("lh2", 4'd3, 32'h0000_0102, 32'd0, 32'h80FF_7F01, 1'b1, 0, 1);
    do_instr("lhu0", 4'd4, 32'h0000_0100, 32'd0, 32'h80FF_7F01, 1'b1, 2, 2);
    do_instr("sb", 4'd6, 32'h0000_2001, 32'h1234_56AB, 32'd0, 1'b0, 0, 0);
    do_instr("sh", 4'd7, 32'h0000_2002, 32'h89AB_CDEF, 32'd0, 1'b0, 1, 1);
    do_instr("lw_mis", 4'd5, 32'h0000_3002, 32'd0, 32'd0, 1'b1, 0, 0);
    do_instr("sh_mis", 4'd7, 32'h0000_3001, 32'h1111_2222, 32'd0, 1'b0, 0, 0);
    do_instr("alu", 4'd0, 32'hCAFE_0001, 32'd0, 32'd0, 1'b1, 0, 0);
    do_instr("op12", 4'd12, 32'h0BAD_0003, 32'd0, 32'd0, 1'b1, 0, 0);

    // Flush while waiting for data: the access must drain in DISCARD.
    drive_ex(4'd5, 32'h2000_0008, 32'd0, 5'd7, 1'b1, 32'h0040_0010);
    @(posedge clk); #1;
    drive_ex(4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    bus_if.data_addr_ok_i = 1'b1;
    @(posedge clk); #1;
    bus_if.data_addr_ok_i = 1'b0;
    flush = 1'b1;
    #1 chk("fw.stall", stall, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    chk("fw.discard_stall", stall, 1);
    chk("fw.discard_req", bus_if.data_req_o, 0);
    chk("fw.discard_we", mem_we, 0);
    @(posedge clk); #1;
    bus_if.data_data_ok_i = 1'b1;
    bus_if.data_rdata_i = $urandom;
    #1;
    chk("fw.dok_stall", stall, 0);
    chk("fw.dok_we", mem_we, 0);
    @(posedge clk); #1;
    bus_if.data_data_ok_i = 1'b0;
    #1;
    chk("fw.idle_stall", stall, 0);
    chk("fw.idle_req", bus_if.data_req_o, 0);

    // Flush before addr_ok withdraws the request.
    drive_ex(4'd8, 32'h3000_0010, 32'h7777_8888, 5'd0, 1'b0, 32'h0040_0020);
    @(posedge clk); #1;
    drive_ex(4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    flush = 1'b1;
    #1 chk("fr.req_before", bus_if.data_req_o, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    chk("fr.req_after", bus_if.data_req_o, 0);
    chk("fr.stall_after", stall, 0);

    // Reset in the middle of a WAIT.
    drive_ex(4'd5, 32'h4000_0004, 32'd0, 5'd9, 1'b1, 32'h0040_0030);
    @(posedge clk); #1;
    drive_ex(4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    bus_if.data_addr_ok_i = 1'b1;
    @(posedge clk); #1;
    bus_if.data_addr_ok_i = 1'b0;
    bus_if.data_rdata_i = 32'hFFFF_FFFF;
    rst = 1'b1;
    #1 chk("rw.stall_before", stall, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rw.stall", stall, 0);
    chk("rw.req", bus_if.data_req_o, 0);
    chk("rw.we", mem_we, 0);
    chk("rw.wdata", mem_wdata, 0);
    chk("rw.pc", mem_pc, 0);
    chk("rw.addr", bus_if.data_addr_o, 0);
    chk("rw.badvaddr", badvaddr, 0);
    chk("rw.waddr", mem_waddr, 0);

    for (int i = 0; i < 60; i++) begin
      do_instr("rnd", 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom, 1'($urandom),
               $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

EX/MEM pipeline register plus MEM-stage load/store engine of the 5-stage MIPS core. Captures the execute-stage result, store data and destination, drives an SRAM-like data bus (req/addr_ok/data_ok), aligns/extends load data, detects address-error exceptions, and stalls the pipeline while an access is outstanding. Its `mem_*` outputs feed the MEM/WB register and the execute-stage forwarding inputs.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `ex_aluout_i`  in  32  EX result; effective address for loads/stores
- `ex_rdata2_i`  in  32  forwarded rt value (store data)
- `ex_waddr_i`  in  5  destination register
- `ex_we_i`  in  1  register write enable
- `ex_mem_op_i`  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9–15 treated as none
- `ex_pc_i`  in  32  instruction PC
- `flush_i`  in  1  kill the instruction entering and the one in MEM
- `data_req_o`  out  1  bus request
- `data_wr_o`  out  1  1 store, 0 load
- `data_size_o`  out  2  0 byte, 1 half, 2 word
- `data_addr_o`  out  32  byte address
- `data_wdata_o`  out  32  lane-replicated store data
- `data_addr_ok_i`  in  1  request accepted this cycle
- `data_data_ok_i`  in  1  transaction complete; `data_rdata_i` valid
- `data_rdata_i`  in  32  load data
- `stall_o`  out  1  hold IF..EX and this stage's register
- `mem_wdata_o`  out  32  MEM-stage write-back value
- `mem_waddr_o`  out  5  destination register
- `mem_we_o`  out  1  effective write enable
- `mem_pc_o`  out  32  PC of MEM instruction
- `adel_o`, `ades_o`  out  1 each  load / store address error
- `badvaddr_o`  out  32  faulting address (= registered address)

## Operation
- Pipeline register (addr, wdata, waddr, we, op, pc) loads from `ex_*` when `!stall_o`. `flush_i` loads a bubble (op=0, we=0, pc=0) regardless of stall.
- Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0. Misaligned load → `adel_o`; store → `ades_o`. No bus request; `mem_we_o`=0.
- Store data: SB = {4{rt[7:0]}}, SH = {2{rt[15:0]}}, SW = rt. `data_addr_o` is the full address.
- Load extraction by addr[1:0]: byte lane k = rdata[8k+7:8k]; half lane = addr[1] ? rdata[31:16] : rdata[15:0]; LB/LH sign-extend, LBU/LHU zero-extend.
- `mem_wdata_o` = extracted load data for loads; registered ALU result otherwise. `mem_we_o` = registered we & no address error.
- FSM states:
  - IDLE: no access pending.
  - REQ: `data_req_o`=1, bus outputs stable; on `addr_ok` → WAIT.
  - WAIT: `data_req_o`=0; on `data_ok` → IDLE.
  - DISCARD: flushed in WAIT; on `data_ok` → IDLE; data dropped.
- Entry: at an edge where the register loads an aligned load/store (not flushed) → REQ; otherwise → IDLE.
- `stall_o` = REQ | (WAIT & !data_ok) | (DISCARD & !data_ok).
- Flush handling:
  - flush in REQ without `addr_ok` → IDLE, request withdrawn.
  - flush in REQ with `addr_ok`, or in WAIT without `data_ok` → DISCARD.
- Load-use hazards are resolved in decode, not here.

## Timing
- Reset: all registers 0, state IDLE. All outputs 0 (`stall_o`=0, `data_req_o`=0, `mem_we_o`=0).
- Minimum load/store latency: 3 cycles in MEM (REQ cycle with `addr_ok`, one WAIT cycle, then `data_ok`). Longer if the bus delays.
- `data_ok` never arrives in the same cycle as its `addr_ok`; the bench must respect this.
- In the `data_ok` cycle, `mem_wdata_o` is valid and `stall_o`=0, so MEM/WB captures it at that edge.
- Non-memory and faulting instructions occupy MEM one cycle, no stall.
- Bus outputs hold constant from REQ entry until `addr_ok`.

## Test plan
- Aligned LW of 0x1000_0004, bus `addr_ok` cycle 1, `data_ok` cycle 3 with rdata 0xDEAD_BEEF → req size 2, stall for 2 cycles, `mem_wdata_o`=0xDEADBEEF, we=1.
- LB/LBU/LH/LHU on rdata 0x80FF_7F01:
  - LB @addr[1:0]=3 → 0xFFFF_FF80
  - LBU @3 → 0x80
  - LH @2 → 0xFFFF_80FF
  - LHU @0 → 0x7F01
- SB of rt=0x1234_56AB @0x..01 → data_wr=1, size 0, wdata 0xABAB_ABAB; SH rt=0x...CDEF → 0xCDEF_CDEF.
- LW @0x...02 → `adel_o`=1, badvaddr=addr, no req, `mem_we_o`=0, no stall. SH @0x...01 → `ades_o`=1.
- `flush_i` during WAIT → DISCARD, stall held until `data_ok`, then IDLE with `mem_we_o`=0. Flush in REQ before `addr_ok` → req drops next cycle.
- Reset asserted mid-WAIT → next cycle state IDLE, all outputs 0.
